mul_writeback_buffer: RTL
=========================

// Module: mul_writeback_buffer
// PURPOSE
//  - Sits after bank_MUL4_MUL5 and consumes the MUL5 instruction, result and ROB tag.
//  - Queues finished multiplies in a DEPTH-entry FIFO and writes them to the shared ROB write port.
//  - The ALU path has priority on that port.
//  - Drives load_MUL to freeze the MUL pipeline banks when the FIFO is full.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  PTR_W   2   log2(DEPTH); pointer width
// PORTS
//  clk               in   1            clock; all state changes on posedge
//  reset             in   1            asynchronous, active-low; 0 -> clear all state immediately
//  instruction_MUL5  in   `DATA_SIZE   MUL5 instruction; all-zero = bubble
//  ALU_out_MUL5      in   `DATA_SIZE   MUL5 product
//  tag_MUL5          in   `ROB_WIDTH   MUL5 ROB tag
//  rob_port_busy     in   1            ALU owns the ROB write port this cycle
//  flush             in   1            mispredict/exception; discard all queued results
//  load_MUL          out  1            load enable to MUL bank chain; 0 = stall
//  rob_wr_en         out  1            ROB write strobe
//  rob_wr_tag        out  `ROB_WIDTH   ROB entry to write
//  rob_wr_data       out  `DATA_SIZE   result to write
//  rob_wr_instr      out  `DATA_SIZE   instruction word (dest decode in ROB)
//  occupancy         out  PTR_W+1      queued entry count, 0..DEPTH
// BEHAVIOUR
//  - Reset (reset==0, async):
//      - count=0, rd/wr ptr=0, all entries zeroed.
//      - Outputs: rob_wr_en=0, rob_wr_tag=0, rob_wr_data=0, rob_wr_instr=0, occupancy=0, load_MUL=1.
//  - valid = (instruction_MUL5 != 0).
//  - load_MUL = (count != DEPTH). Driven from state only; no combinational path from rob_port_busy.
//  - push = valid & load_MUL & ~flush. Writes {instr, data, tag} at wr_ptr; wr_ptr++ mod DEPTH.
//      - While load_MUL=0 the MUL banks hold MUL5 steady.
//      - The held instruction is accepted exactly once, in the first cycle load_MUL=1. No duplicates.
//  - rob_wr_en = (count!=0) & ~rob_port_busy & ~flush.
//      - rob_wr_* come combinationally from the head entry (registered storage).
//      - pop = rob_wr_en; rd_ptr++ mod DEPTH.
//  - Ordering: strict FIFO; results reach the ROB in MUL5 order.
//  - Latency (base build): accepted at edge N -> rob_wr_en high earliest in the cycle after edge N.
//  - count_next = count + push - pop.
//      - Simultaneous push and pop leaves count unchanged.
//      - Full: no push possible, so pop alone frees a slot. load_MUL rises the next cycle.
//      - Empty: pop impossible.
//      - Pointers wrap at DEPTH with no extra state.
//  - rob_port_busy held high: head is held unchanged, no drop, no reorder.
//  - flush=1 (synchronous, top priority):
//      - Same cycle: rob_wr_en=0, push suppressed.
//      - Next edge: count=0 and ptrs=0. Entry contents may stay stale.
//      - Next cycle: load_MUL=1.
//  - rob_wr_tag/data/instr are 0 whenever count==0 (base build). Head mux output is gated to 0.
//  - Reset asserted mid-operation: all queued results are lost, with no ROB write.
// CONFIGURATION
//  - MUL_WB_BYPASS_EN defined:
//      - Bypass condition: count==0, valid, ~rob_port_busy, ~flush.
//      - rob_wr_* driven combinationally from the MUL5 inputs; rob_wr_en=1 in that same cycle.
//      - That instruction is not enqueued (push=0): zero-cycle latency.
//      - If count!=0 the head has priority and MUL5 is enqueued normally. Order is preserved.
//  - Undefined: no bypass. Every result passes through the FIFO (min 1 cycle). Nothing from MUL5 reaches rob_wr_* combinationally.
// TESTING
//  - Reset: hold reset=0 with nonzero inputs -> rob_wr_en=0, load_MUL=1, occupancy=0; release -> still idle until a valid MUL5.
//  - Single result, busy=0: instr=0x00430018, data=0x0000_0A2C, tag=3 at edge N -> next cycle rob_wr_en=1, tag=3, data=0x0A2C; occupancy back to 0 after edge. Bypass build: write same cycle, occupancy stays 0.
//  - Backpressure: rob_port_busy=1, feed 5 distinct results (tags 1..5) -> occupancy reaches 4, load_MUL=0, tag 5 held; drop busy -> ROB writes tags 1,2,3,4,5 in order, exactly once each.
//  - Full with push+pop: count=4, busy low one cycle -> one pop; next cycle load_MUL=1, held tag accepted, occupancy=4 again; no duplicate of held tag.
//  - Flush: 3 queued, valid MUL5 present, flush=1 -> rob_wr_en=0 that cycle; next cycle occupancy=0, load_MUL=1, no ROB write of flushed tags.
//  - Wrap/bubbles: stream 10 results interleaved with zero instructions, busy toggling -> bubbles never written, all 10 tags in order across pointer wrap.

Source files
------------

// File: rtl/mul_writeback_buffer.sv
// mul_writeback_buffer: queues MUL5 results and drains them in order to the shared ROB write port, ALU first.
// Build option: define MUL_WB_BYPASS_EN to write MUL5 straight to the ROB when the queue is empty.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
module mul_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [`DATA_SIZE-1:0]  instruction_MUL5,
  input  logic [`DATA_SIZE-1:0]  ALU_out_MUL5,
  input  logic [`ROB_WIDTH-1:0]  tag_MUL5,
  input  logic                   rob_port_busy,
  input  logic                   flush,
  output logic                   load_MUL,
  output logic                   rob_wr_en,
  output logic [`ROB_WIDTH-1:0]  rob_wr_tag,
  output logic [`DATA_SIZE-1:0]  rob_wr_data,
  output logic [`DATA_SIZE-1:0]  rob_wr_instr,
  output logic [PTR_W:0]         occupancy
);
  logic [`DATA_SIZE-1:0] instr_q [DEPTH];
  logic [`DATA_SIZE-1:0] data_q [DEPTH];
  logic [`ROB_WIDTH-1:0] tag_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic valid, push, pop, has_head;
  assign valid = |instruction_MUL5;
  assign has_head = count != '0;
  assign load_MUL = count != (PTR_W+1)'(DEPTH);
  assign pop = has_head & ~rob_port_busy & ~flush;
  assign occupancy = count;
`ifdef MUL_WB_BYPASS_EN
  logic byp;
  assign byp = ~has_head & valid & ~rob_port_busy & ~flush;
  assign push = valid & load_MUL & ~flush & ~byp;
  assign rob_wr_en = pop | byp;
  always_comb begin
    rob_wr_tag = byp ? tag_MUL5 : has_head ? tag_q[rd_ptr] : '0;
    rob_wr_data = byp ? ALU_out_MUL5 : has_head ? data_q[rd_ptr] : '0;
    rob_wr_instr = byp ? instruction_MUL5 : has_head ? instr_q[rd_ptr] : '0;
  end
`else
  assign push = valid & load_MUL & ~flush;
  assign rob_wr_en = pop;
  always_comb begin
    rob_wr_tag = has_head ? tag_q[rd_ptr] : '0;
    rob_wr_data = has_head ? data_q[rd_ptr] : '0;
    rob_wr_instr = has_head ? instr_q[rd_ptr] : '0;
  end
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        data_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= instruction_MUL5;
        data_q[wr_ptr] <= ALU_out_MUL5;
        tag_q[wr_ptr] <= tag_MUL5;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
endmodule
